// File: rtl/stack_mem_responder_if.sv
// Request/response bus between the stack controller (master) and the
// stack memory responder (slave).
interface stack_mem_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    // Handshake: master raises req with wr/addr/wdata stable and holds it until
    // ack; ack is a one-cycle pulse carrying fault and (for reads) rdata; the
    // slave samples a new req no earlier than the cycle after ack.
    logic              req;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              fault;
    logic              stall;

    modport master (
        output req, wr, addr, wdata,
        input  rdata, ack, fault, stall
    );

    modport slave (
        input  req, wr, addr, wdata,
        output rdata, ack, fault, stall
    );
endinterface

// File: rtl/stack_mem_responder.sv
// Stack SRAM responder: one request at a time, window/alignment fault checks,
// configurable read latency, low-water mark and saturating fault count.
module stack_mem_responder #(
    parameter int                ADDR_W = 16,
    parameter int                DATA_W = 32,
    parameter logic [ADDR_W-1:0] BASE   = 16'h5400,
    parameter int                DEPTH  = 64,
    parameter int                RD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    stack_mem_responder_if.slave bus,
    input  logic                 clr_wm_i,
    output logic [ADDR_W-1:0]    low_water_o,
    output logic [7:0]           fault_cnt_o,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    localparam int                IDXW   = $clog2(DEPTH);
    // One extra bit so BASE+4*DEPTH cannot wrap at the top of the address space.
    localparam logic [ADDR_W:0]   BASE_X = {1'b0, BASE};
    localparam logic [ADDR_W:0]   TOP_X  = BASE_X + (ADDR_W+1)'(4 * DEPTH);
    localparam logic [ADDR_W-1:0] LW_RST = TOP_X[ADDR_W-1:0];
    localparam logic [2:0]        LAT_M1 = 3'(RD_LAT - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q;
    logic [2:0]        cnt_q;
    logic [IDXW-1:0]   idx_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ack_q;
    logic              fault_q;
    logic [ADDR_W-1:0] low_water_q;
    logic [7:0]        fault_cnt_q;

    logic [ADDR_W:0]   addr_x;
    logic              bad_d;
    logic [IDXW-1:0]   idx_d;
    logic              wr_commit;

    always_comb begin
        addr_x    = {1'b0, bus.addr};
        bad_d     = (bus.addr[1:0] != 2'b00) || (addr_x < BASE_X) || (addr_x >= TOP_X);
        idx_d     = IDXW'((bus.addr - BASE) >> 2);
        wr_commit = (state_q == IDLE) && bus.req && bus.wr && !bad_d;
    end

    // SRAM array: no reset, contents survive resetn.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            mem[idx_d] <= bus.wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            rdata_q     <= '0;
            ack_q       <= 1'b0;
            fault_q     <= 1'b0;
            low_water_q <= LW_RST;
            fault_cnt_q <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        idx_q <= idx_d;
                        if (bad_d) begin
                            fault_q <= 1'b1;
                            rdata_q <= '0;
                            ack_q   <= 1'b1;
                            state_q <= RESP;
                            if (fault_cnt_q != 8'hFF) begin
                                fault_cnt_q <= fault_cnt_q + 8'd1;
                            end
                        end else if (bus.wr) begin
                            fault_q <= 1'b0;
                            ack_q   <= 1'b1;
                            state_q <= RESP;
                            if (bus.addr < low_water_q) begin
                                low_water_q <= bus.addr;
                            end
                        end else begin
                            fault_q <= 1'b0;
                            cnt_q   <= LAT_M1;
                            if (LAT_M1 == 3'd0) begin
                                rdata_q <= mem[idx_d];
                                ack_q   <= 1'b1;
                                state_q <= RESP;
                            end else begin
                                state_q <= RD_WAIT;
                            end
                        end
                    end
                end
                RD_WAIT: begin
                    // Requester withdrew: drop the read silently.
                    if (!bus.req) begin
                        state_q <= IDLE;
                    end else if (cnt_q == 3'd1) begin
                        cnt_q   <= 3'd0;
                        rdata_q <= mem[idx_q];
                        ack_q   <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            if (clr_wm_i) begin
                low_water_q <= LW_RST;
                fault_cnt_q <= '0;
            end
        end
    end

    assign bus.rdata   = rdata_q;
    assign bus.ack     = ack_q;
    assign bus.fault   = fault_q;
    assign bus.stall   = bus.req & ~ack_q;
    assign low_water_o = low_water_q;
    assign fault_cnt_o = fault_cnt_q;
    assign state_o     = state_q;

endmodule

// File: doc/stack_mem_responder.md
Name: stack_mem_responder

Overview:
Memory-side responder for the stack controller's data-memory requests (PUSH stores, POP/LDR-SP loads, STR-SP stores).
- Owns a word-organised stack SRAM covering a fixed address window below the default SP.
- Serves one request at a time over a level-req / pulse-ack handshake, with configurable read latency.
- Flags out-of-window or misaligned accesses, and tracks the stack low-water mark and fault count for debug.

Parameters:
- ADDR_W, 16, byte-address width.
- DATA_W, 32, data word width.
- BASE, 16'h5400, lowest byte address of stack window; must be 4-aligned.
- DEPTH, 64, window size in 32-bit words; window is [BASE, BASE+4*DEPTH), so the default top is 16'h5500.
- RD_LAT, 2, cycles from read accept to ack; legal range 1..7.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- req  in  1  request valid; held high, with addr/wr/wdata stable, until ack.
- wr  in  1  1 = write, 0 = read.
- addr  in  ADDR_W  byte address.
- wdata  in  DATA_W  write data.
- rdata  out  DATA_W  read data; valid only in the ack cycle.
- ack  out  1  one-cycle completion pulse.
- fault  out  1  valid with ack; 1 = access rejected.
- stall  out  1  combinational req & ~ack; feeds the CPU stall / ST_Wen gating.
- clr_wm  in  1  synchronous clear of watermark and fault count.
- low_water  out  ADDR_W  lowest address successfully written since reset/clear.
- fault_cnt  out  8  saturating count of faulted accesses.

Behaviour:
- Reset values: rdata=0, ack=0, fault=0, low_water=BASE+4*DEPTH, fault_cnt=0, FSM=IDLE. SRAM contents are not cleared and are undefined after power-up.
- FSM states: IDLE, RD_WAIT, RESP.
- IDLE, req=0: stay in IDLE.
- IDLE, req=1: accept the request and compute `bad` = addr[1:0]!=0, or addr<BASE, or addr>=BASE+4*DEPTH. Comparisons are unsigned at ADDR_W+1 bits so the top bound does not overflow.
  - bad: go to RESP with fault=1 and rdata=0. No SRAM access. fault_cnt increments, saturating at 255.
  - good write: SRAM[(addr-BASE)>>2] <= wdata in the accept cycle. low_water <= min(low_water, addr). Go to RESP.
  - good read: load the latency counter with RD_LAT-1. If it is 0, capture rdata and go to RESP; otherwise go to RD_WAIT.
- RD_WAIT: decrement the counter. When it reaches 0, register rdata = SRAM[index] and go to RESP. If req drops in RD_WAIT, abort to IDLE with no ack and no fault.
- RESP: ack=1 for exactly this cycle and req is ignored; next state is IDLE.
- Latency:
  - write: accept at cycle N, ack at N+1.
  - read: ack at N+RD_LAT.
  - fault: ack at N+1.
  - A new request is sampled no earlier than the cycle after ack. Minimum spacing of back-to-back accesses is 2 cycles for a write and RD_LAT+1 for a read.
- Writes are committed at accept. A req drop after accept does not undo the write, and ack is still issued.
- Priority: clr_wm takes priority over a same-cycle low_water update and fault_cnt increment; it clears both to their reset values.
- Window edges:
  - addr=BASE and addr=BASE+4*DEPTH-4 are legal.
  - addr=BASE+4*DEPTH (for example a POP at empty SP 0x5500) faults.
  - addr=BASE-4 (for example a PUSH past full) faults.
- Reset asserted mid-transaction: FSM returns to IDLE immediately, no ack is issued, and an in-flight read is dropped. A write already committed remains in SRAM.
- rdata holds its last value outside ack; consumers must sample only when ack=1.

Test Plan:
1. Reset, then write 0xDEADBEEF to 0x54FC → ack 1 cycle after accept, fault=0, low_water=0x54FC. Then read 0x54FC → ack 2 cycles after accept, rdata=0xDEADBEEF.
2. PUSH-style burst: write 0x11, 0x22, 0x33 to 0x54FC, 0x54F8, 0x54F4, then read them back in reverse order → 0x33, 0x22, 0x11. low_water=0x54F4. stall high on every non-ack request cycle.
3. Faults: read 0x5500, write 0x53FC, read 0x5402 → each acks after 1 cycle with fault=1 and rdata=0. fault_cnt=3. SRAM at 0x5400 unchanged.
4. Issue 260 faulting accesses → fault_cnt saturates at 255. Then assert clr_wm with a faulting ack in the same cycle → fault_cnt=0 and low_water=0x5500.
5. Abort: read 0x5480, drop req in RD_WAIT → no ack; FSM back in IDLE; next write accepted normally.
6. Assert resetn low during RD_WAIT → ack never pulses, outputs at reset values. Data written before the reset is still readable at the same address afterwards.
